// File: rtl/vend_controller_if.sv
// Bus between the vending controller and its surroundings: coin, button and
// price-block inputs plus the credit/dispense/refund/status outputs.
interface vend_controller_if;
   logic [3:0] sel;
   logic [9:0] p;
   logic       coin_valid;
   logic [1:0] coin_value;
   logic       purchase;
   logic       cancel;

   logic [9:0] credit;
   logic [3:0] dispense;
   logic [9:0] change;
   logic       change_valid;
   logic       coin_reject;
   logic       insufficient;
   logic       busy;

   modport slave (
      input  sel, p, coin_valid, coin_value, purchase, cancel,
      output credit, dispense, change, change_valid, coin_reject, insufficient, busy
   );

   modport master (
      output sel, p, coin_valid, coin_value, purchase, cancel,
      input  credit, dispense, change, change_valid, coin_reject, insufficient, busy
   );
endinterface

// File: rtl/vend_controller.sv
// Coin-operated vending controller: credit accumulation, purchase, refund.
// Optional inactivity refund is built in when COIN_TIMEOUT_EN is defined.
module vend_controller #(
   parameter int MAX_CREDIT     = 995,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input logic               clk,
   input logic               reset,
   vend_controller_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_e;

   state_e     state_q;
   logic [9:0] credit_q;
   logic [9:0] price_q;
   logic [3:0] dispense_q;
   logic [9:0] change_q;
   logic       change_valid_q;
   logic       coin_reject_q;
   logic       insufficient_q;
   logic       busy_q;

   logic [9:0]  coin_cents;
   logic [10:0] coin_sum;
   logic        coin_fits;
   logic        cancel_hit;
   logic        buy_hit;
   logic        can_afford;

   always_comb begin
      coin_cents = 10'd100;
      case (bus.coin_value)
         2'd0:    coin_cents = 10'd5;
         2'd1:    coin_cents = 10'd10;
         2'd2:    coin_cents = 10'd25;
         default: coin_cents = 10'd100;
      endcase
   end

   // One extra bit so an over-limit coin can never wrap back into range.
   assign coin_sum   = {1'b0, credit_q} + {1'b0, coin_cents};
   assign coin_fits  = coin_sum <= 11'(MAX_CREDIT);
   assign cancel_hit = bus.cancel && (state_q == COLLECT);
   assign buy_hit    = bus.purchase && (bus.p != 10'd0) &&
                       ((state_q == IDLE) || (state_q == COLLECT));
   assign can_afford = credit_q >= bus.p;

`ifdef COIN_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] idle_cnt_q;
   logic             collect_event;
   assign collect_event = cancel_hit || buy_hit || (bus.coin_valid && coin_fits);
`else
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT_CYCLES;
`endif

   // NOTE: non-blocking assignments only, so every branch sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         credit_q       <= '0;
         price_q        <= '0;
         dispense_q     <= '0;
         change_q       <= '0;
         change_valid_q <= 1'b0;
         coin_reject_q  <= 1'b0;
         insufficient_q <= 1'b0;
         busy_q         <= 1'b0;
`ifdef COIN_TIMEOUT_EN
         idle_cnt_q     <= '0;
`endif
      end else begin
         dispense_q     <= '0;
         change_q       <= '0;
         change_valid_q <= 1'b0;
         coin_reject_q  <= 1'b0;
         insufficient_q <= 1'b0;

         unique case (state_q)
            IDLE, COLLECT: begin
               busy_q <= 1'b0;
               if (cancel_hit) begin
                  state_q        <= CHANGE;
                  busy_q         <= 1'b1;
                  price_q        <= '0;
                  change_valid_q <= 1'b1;
                  change_q       <= credit_q;
                  coin_reject_q  <= bus.coin_valid;
               end else if (buy_hit) begin
                  coin_reject_q <= bus.coin_valid;
                  if (can_afford) begin
                     state_q    <= DISPENSE;
                     busy_q     <= 1'b1;
                     price_q    <= bus.p;
                     dispense_q <= bus.sel;
                  end else begin
                     insufficient_q <= 1'b1;
                  end
               end else if (bus.coin_valid) begin
                  if (coin_fits) begin
                     credit_q <= coin_sum[9:0];
                     state_q  <= COLLECT;
                  end else begin
                     coin_reject_q <= 1'b1;
                  end
               end
            end
            DISPENSE: begin
               state_q        <= CHANGE;
               change_valid_q <= 1'b1;
               change_q       <= credit_q - price_q;
               coin_reject_q  <= bus.coin_valid;
            end
            CHANGE: begin
               state_q       <= IDLE;
               credit_q      <= '0;
               busy_q        <= 1'b0;
               coin_reject_q <= bus.coin_valid;
            end
         endcase

`ifdef COIN_TIMEOUT_EN
         // A quiet COLLECT cycle advances the counter; expiry refunds like a cancel.
         if ((state_q == COLLECT) && !collect_event) begin
            if (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_q        <= CHANGE;
               busy_q         <= 1'b1;
               price_q        <= '0;
               change_valid_q <= 1'b1;
               change_q       <= credit_q;
               idle_cnt_q     <= '0;
            end else begin
               idle_cnt_q <= idle_cnt_q + 1'b1;
            end
         end else begin
            idle_cnt_q <= '0;
         end
`endif
      end
   end

   assign bus.credit       = credit_q;
   assign bus.dispense     = dispense_q;
   assign bus.change       = change_q;
   assign bus.change_valid = change_valid_q;
   assign bus.coin_reject  = coin_reject_q;
   assign bus.insufficient = insufficient_q;
   assign bus.busy         = busy_q;

endmodule
